// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and named register indices.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/reg_read_port.sv
// One combinational register-file read port with same-cycle write-through bypass.
module reg_read_port #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_read_idx,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_write_idx,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [DATA_W-1:0] i_store_word,
  output logic [DATA_W-1:0] o_read_data
);
  import mips_pkg::*;

  logic w_zero_sel;
  logic w_bypass;

  // Register 0 always reads zero; otherwise an in-flight write to the same index wins over storage.
  always_comb begin
    w_zero_sel = (i_read_idx == ADDR_W'(REG_ZERO));
    w_bypass   = i_write && (i_write_idx == i_read_idx) && (i_write_idx != ADDR_W'(REG_ZERO));
    if (w_zero_sel) begin
      o_read_data = '0;
    end else if (w_bypass) begin
      o_read_data = i_write_data;
    end else begin
      o_read_data = i_store_word;
    end
  end

endmodule : reg_read_port

// File: rtl/register_file_wb.sv
// MIPS write-back register file: 32 GPRs, two bypassed read ports, a committed-state
// debug port and a wrapping count of committed writes.
module register_file_wb #(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned NUM_REGS = mips_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Write,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DebugRegister,
  output logic [DATA_W-1:0] DebugData,
  output logic [15:0]       WriteCount
);
  import mips_pkg::*;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [15:0]       r_wcount;
  logic              w_commit;
  logic [DATA_W-1:0] w_word1;
  logic [DATA_W-1:0] w_word2;

  // A write commits only when strobed and not aimed at the hardwired zero register.
  always_comb begin
    w_commit = Write && (WriteRegister != ADDR_W'(REG_ZERO));
  end

  // Storage update; register 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_regs <= '{default: '0};
    end else if (w_commit) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  // Committed-write counter, wrapping naturally at 16 bits.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wcount <= '0;
    end else if (w_commit) begin
      r_wcount <= r_wcount + 16'd1;
    end
  end

  // Storage words feeding the read ports and the unbypassed debug view.
  always_comb begin
    w_word1   = r_regs[ReadRegister1];
    w_word2   = r_regs[ReadRegister2];
    DebugData = r_regs[DebugRegister];
  end

  assign WriteCount = r_wcount;

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port1 (
    .i_read_idx   (ReadRegister1),
    .i_write      (Write),
    .i_write_idx  (WriteRegister),
    .i_write_data (WriteData),
    .i_store_word (w_word1),
    .o_read_data  (ReadData1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_port2 (
    .i_read_idx   (ReadRegister2),
    .i_write      (Write),
    .i_write_idx  (WriteRegister),
    .i_write_data (WriteData),
    .i_store_word (w_word2),
    .o_read_data  (ReadData2)
  );

endmodule : register_file_wb

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: reset, write/read, zero register, bypass,
// async reset mid-stream and write-counter wrap.
module tb_register_file_wb;
  import mips_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        Write;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  DebugRegister;
  logic [31:0] DebugData;
  logic [15:0] WriteCount;

  int checks = 0;
  int errors = 0;

  register_file_wb #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .ADDR_W   (5)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Write         (Write),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .DebugRegister (DebugRegister),
    .DebugData     (DebugData),
    .WriteCount    (WriteCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b0;
    Write = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    DebugRegister = '0;

    // Reset held for 3 cycles
    repeat (3) @(posedge Clk);
    #1 chk("cnt_in_reset", 32'(WriteCount), 32'h0);
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(i);
      DebugRegister = 5'(i);
      #1;
      chk("rst_rd1", ReadData1, 32'h0);
      chk("rst_rd2", ReadData2, 32'h0);
      chk("rst_dbg", DebugData, 32'h0);
    end
    chk("rst_cnt", 32'(WriteCount), 32'h0);

    // Basic write/read
    @(negedge Clk);
    Write = 1'b1; WriteRegister = 5'd8; WriteData = 32'hDEADBEEF;
    ReadRegister1 = 5'd0; DebugRegister = 5'd8;
    @(negedge Clk);
    Write = 1'b0; ReadRegister1 = 5'd8;
    #1;
    chk("wr8_rd1", ReadData1, 32'hDEADBEEF);
    chk("wr8_dbg", DebugData, 32'hDEADBEEF);
    chk("wr8_cnt", 32'(WriteCount), 32'h1);

    // Zero register write is discarded
    @(negedge Clk);
    Write = 1'b1; WriteRegister = 5'd0; WriteData = 32'h12345678;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; DebugRegister = 5'd0;
    #1;
    chk("z_same_rd1", ReadData1, 32'h0);
    chk("z_same_rd2", ReadData2, 32'h0);
    @(negedge Clk);
    Write = 1'b0;
    #1;
    chk("z_after_rd1", ReadData1, 32'h0);
    chk("z_after_rd2", ReadData2, 32'h0);
    chk("z_after_dbg", DebugData, 32'h0);
    chk("z_cnt", 32'(WriteCount), 32'h1);

    // Bypass plus gating
    @(negedge Clk);
    Write = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1;
    @(negedge Clk);
    WriteData = 32'h2; ReadRegister1 = 5'd9; ReadRegister2 = 5'd9; DebugRegister = 5'd9;
    #1;
    chk("byp_rd2", ReadData2, 32'h2);
    chk("byp_rd1", ReadData1, 32'h2);
    chk("byp_dbg", DebugData, 32'h1);
    @(negedge Clk);
    Write = 1'b0; WriteData = 32'h3;
    #1;
    chk("gate_rd2", ReadData2, 32'h2);
    chk("gate_dbg", DebugData, 32'h2);
    @(negedge Clk);
    #1;
    chk("gate_rd2_later", ReadData2, 32'h2);
    chk("gate_cnt", 32'(WriteCount), 32'h3);

    // Back-to-back writes to one register: last wins, bypass shows newest
    @(negedge Clk);
    Write = 1'b1; WriteRegister = 5'd10; WriteData = 32'h10;
    ReadRegister1 = 5'd10; DebugRegister = 5'd10;
    @(negedge Clk);
    WriteData = 32'h20;
    #1;
    chk("b2b_rd1", ReadData1, 32'h20);
    chk("b2b_dbg_prev", DebugData, 32'h10);
    @(negedge Clk);
    Write = 1'b0;
    #1;
    chk("b2b_dbg", DebugData, 32'h20);
    chk("b2b_cnt", 32'(WriteCount), 32'h5);

    // Async reset mid-stream
    @(negedge Clk);
    Write = 1'b1; WriteRegister = REG_RA; WriteData = 32'hAAAA5555;
    @(negedge Clk);
    Write = 1'b0; ReadRegister1 = REG_RA; ReadRegister2 = 5'd8; DebugRegister = REG_RA;
    #1;
    chk("ra_rd1", ReadData1, 32'hAAAA5555);
    chk("ra_cnt", 32'(WriteCount), 32'h6);
    #1 Rst = 1'b0;
    #1;
    chk("arst_rd1", ReadData1, 32'h0);
    chk("arst_dbg", DebugData, 32'h0);
    chk("arst_rd2", ReadData2, 32'h0);
    chk("arst_cnt", 32'(WriteCount), 32'h0);
    @(negedge Clk);
    Write = 1'b1; WriteRegister = REG_RA; WriteData = 32'h5A5A5A5A;
    #1;
    chk("arst_bypass", ReadData1, 32'h5A5A5A5A);
    @(negedge Clk);
    Write = 1'b0; Rst = 1'b1;
    #1;
    chk("arst_lost_rd1", ReadData1, 32'h0);
    chk("arst_lost_dbg", DebugData, 32'h0);
    chk("arst_lost_cnt", 32'(WriteCount), 32'h0);

    // Counter wrap: 0xFFFF writes to reg1, then one more
    @(negedge Clk);
    Write = 1'b1; WriteRegister = 5'd1; DebugRegister = 5'd1; ReadRegister2 = REG_SP;
    for (int i = 0; i < 65535; i++) begin
      WriteData = 32'(i);
      @(negedge Clk);
    end
    Write = 1'b0;
    #1;
    chk("wrap_pre_cnt", 32'(WriteCount), 32'h0000FFFF);
    chk("wrap_pre_dbg", DebugData, 32'h0000FFFE);
    chk("wrap_sp_rd2", ReadData2, 32'h0);
    @(negedge Clk);
    Write = 1'b1; WriteData = 32'hCAFEF00D;
    @(negedge Clk);
    Write = 1'b0; ReadRegister1 = 5'd1;
    #1;
    chk("wrap_cnt", 32'(WriteCount), 32'h0);
    chk("wrap_dbg", DebugData, 32'hCAFEF00D);
    chk("wrap_rd1", ReadData1, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_file_wb
